// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the writeback register file.
// Replaces the legacy defines: datapath width, register address width, zero register.
// Optional feature REGFILE_BYPASS_EN is selected per build in wb_regfile.sv.
package wb_regfile_pkg;

    localparam int WIDTH      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // A writeback commits only when enabled and not aimed at the hardwired zero register.
    function automatic logic commit_ok(input logic                  we,
                                       input logic [REG_ADDR_W-1:0] addr);
        return we && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// 2:1 writeback select: load data when sel=1, ALU result otherwise.
// Latency: zero (combinational).
// Backpressure: none; pure datapath.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] alu_dat,
    input  logic [DATA_W-1:0] load_dat,
    output logic [DATA_W-1:0] result
);

    assign result = sel ? load_dat : alu_dat;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 GPRs (r0 hardwired zero), two async read ports, commit counter.
// Latency: write lands on the rising clk edge; reads and wb_result are combinational.
// Backpressure: none; one writeback accepted per cycle. REGFILE_BYPASS_EN adds write-through reads.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = WIDTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite_wb,
    input  logic              memtoreg_wb,
    input  logic [DATA_W-1:0] aluout_wb,
    input  logic [DATA_W-1:0] readdata_wb,
    input  logic [ADDR_W-1:0] regaddr_wb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_result,
    output logic [CNT_W-1:0]  wb_count
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic              commit;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .sel      (memtoreg_wb),
        .alu_dat  (aluout_wb),
        .load_dat (readdata_wb),
        .result   (wb_result)
    );

    assign commit = commit_ok(regwrite_wb, regaddr_wb);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            cnt_q <= '0;
        end else if (commit) begin
            regs[regaddr_wb] <= wb_result;
            cnt_q            <= cnt_q + 1'b1;
        end
    end

    assign wb_count = cnt_q;

`ifdef REGFILE_BYPASS_EN
    // Write-through: a reader of the register being committed sees the new value this cycle.
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (commit && (regaddr_wb == rs_addr)) rs_data = wb_result;
        if (commit && (regaddr_wb == rt_addr)) rt_data = wb_result;
        if (rs_addr == REG_ZERO) rs_data = '0;
        if (rt_addr == REG_ZERO) rt_data = '0;
    end
`else
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        if (rs_addr == REG_ZERO) rs_data = '0;
        if (rt_addr == REG_ZERO) rt_data = '0;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected read/result/count tuples, a monitor compares.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        regwrite_wb = 1'b0;
    logic        memtoreg_wb = 1'b0;
    logic [31:0] aluout_wb = '0;
    logic [31:0] readdata_wb = '0;
    logic [4:0]  regaddr_wb = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_result;
    logic [31:0] wb_count;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .regwrite_wb (regwrite_wb),
        .memtoreg_wb (memtoreg_wb),
        .aluout_wb   (aluout_wb),
        .readdata_wb (readdata_wb),
        .regaddr_wb  (regaddr_wb),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wb_result   (wb_result),
        .wb_count    (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] wb;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    event  chk_ev;
    int    checks = 0;
    int    failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(chk_ev);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "rs_data",   rs_data,   e.rs);
                cmp(nm, "rt_data",   rt_data,   e.rt);
                cmp(nm, "wb_result", wb_result, e.wb);
                cmp(nm, "wb_count",  wb_count,  e.cnt);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] wb, input logic [31:0] cnt);
        exp_t e;
        e.rs = rs; e.rt = rt; e.wb = wb; e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> chk_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic mtr, input logic [31:0] alu, input logic [31:0] ld, input logic [4:0] a);
        regwrite_wb = 1'b1;
        memtoreg_wb = mtr;
        aluout_wb   = alu;
        readdata_wb = ld;
        regaddr_wb  = a;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        #12;
        expect_out("reset_state", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // preload r5 = 0x1234
        wr(1'b0, 32'h0000_1234, 32'h0, 5'd5);
        step();
        regwrite_wb = 1'b0;
        rs_addr = 5'd5; rt_addr = 5'd5;
        #1;
        expect_out("preload_r5", 32'h1234, 32'h1234, 32'h1234, 32'd1);

        // asynchronous reset away from any edge
        rst = 1'b0;
        #1;
        expect_out("async_reset", 32'h0, 32'h0, 32'h1234, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ALU writeback to r7
        wr(1'b0, 32'hDEAD_BEEF, 32'h1111_2222, 5'd7);
        rs_addr = 5'd7; rt_addr = 5'd0;
        #1;
        expect_out("alu_pre", 32'h0, 32'h0, 32'hDEAD_BEEF, 32'd0);
        step();
        expect_out("alu_post", 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'd1);

        // load writeback to r9
        wr(1'b1, 32'h0000_0BAD, 32'hCAFE_F00D, 5'd9);
        rt_addr = 5'd9;
        step();
        expect_out("load_r9", 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'd2);

        // write to r0 is dropped and not counted
        wr(1'b1, 32'h0, 32'h7777_7777, 5'd0);
        rs_addr = 5'd0;
        step();
        expect_out("r0_write", 32'h0, 32'hCAFE_F00D, 32'h7777_7777, 32'd2);

        // same-cycle hazard on r3
        wr(1'b0, 32'h0000_0011, 32'h0, 5'd3);
        step();
        wr(1'b0, 32'h0000_0055, 32'h0, 5'd3);
        rs_addr = 5'd3; rt_addr = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        expect_out("hazard_pre", 32'h55, 32'h55, 32'h55, 32'd3);
`else
        expect_out("hazard_pre", 32'h11, 32'h11, 32'h55, 32'd3);
`endif
        step();
        expect_out("hazard_post", 32'h55, 32'h55, 32'h55, 32'd4);

        // regwrite=0: nothing moves
        regwrite_wb = 1'b0;
        aluout_wb   = 32'h0000_0077;
        step();
        expect_out("no_write", 32'h55, 32'h55, 32'h77, 32'd4);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        rs_addr = 5'd10; rt_addr = 5'd3;
        #1;
        expect_out("cnt_forced", 32'h0, 32'h55, 32'h77, 32'hFFFF_FFFF);
        wr(1'b0, 32'h0000_00A5, 32'h0, 5'd10);
        step();
        expect_out("cnt_wrap", 32'hA5, 32'h55, 32'hA5, 32'h0);

        // reset across an edge that would write r4, then X controls during reset
        wr(1'b0, 32'h0000_00AA, 32'h0, 5'd4);
        rst = 1'b0;
        step();
        regwrite_wb = 1'bx; memtoreg_wb = 1'bx; regaddr_wb = 5'bx;
        step();
        regwrite_wb = 1'b0; memtoreg_wb = 1'b0; regaddr_wb = 5'd4;
        rst = 1'b1;
        rs_addr = 5'd4; rt_addr = 5'd10;
        #1;
        expect_out("reset_drop", 32'h0, 32'h0, 32'hAA, 32'd0);
        wr(1'b0, 32'h0000_00BB, 32'h0, 5'd4);
        step();
        regwrite_wb = 1'b0;
        #1;
        expect_out("post_reset_write", 32'hBB, 32'h0, 32'hBB, 32'd1);

        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
